mips_cpu_mult_div: RTL and testbench

HI/LO multiply-divide unit sitting directly downstream of the register file.
- Consumes the rs/rt read data (read_data_1/read_data_2) for MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Iterates over multiple cycles and holds the HI/LO architectural registers, which MFHI/MFLO read combinationally.
- Raises busy so the control path stalls any further HI/LO access until the result is committed.

---
 rtl/mips_cpu_pkg.sv | 30 +++
 rtl/mips_cpu_div_step.sv | 26 ++
 rtl/mips_cpu_mult_div.sv | 195 +++++++++++++++++++
 tb/tb_mips_cpu_mult_div.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mips_cpu_pkg.sv
// Shared types and constants for the HI/LO multiply-divide unit.
package mips_cpu_pkg;

    // Iterations per multiply or divide, one result bit per cycle.
    localparam int unsigned MULDIV_ITERS = 32;

    typedef enum logic [2:0] {
        OpNop   = 3'd0,
        OpMult  = 3'd1,
        OpMultu = 3'd2,
        OpDiv   = 3'd3,
        OpDivu  = 3'd4,
        OpMthi  = 3'd5,
        OpMtlo  = 3'd6,
        OpRsvd  = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv,
        StFinish
    } muldiv_state_t;

    // Magnitude of a 32-bit value; two's complement absolute value when signed.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mips_cpu_div_step.sv
// One restoring-division step: shifts the next dividend bit into the partial
// remainder, subtracts the divisor when it fits and shifts out a quotient bit.
module mips_cpu_div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0] partial;
    logic [WIDTH:0] diff;
    logic           fits;

    // Trial subtraction; a clear borrow bit means the divisor fits.
    always_comb begin
        partial = {rem_in, quo_in[WIDTH-1]};
        diff    = partial - {1'b0, divisor};
        fits    = ~diff[WIDTH];
        rem_out = fits ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
        quo_out = {quo_in[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/mips_cpu_mult_div.sv
// HI/LO multiply-divide unit. Iterative 32-cycle shift-add multiply and
// restoring divide with a final sign-fix cycle; MTHI/MTLO write directly.
// Optional macro MIPS_MULT_FAST_EN: MULT/MULTU use a single-cycle
// combinational multiply and commit one cycle after acceptance.
module mips_cpu_mult_div
    import mips_cpu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [2:0]       op_code,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntW = $clog2(MULDIV_ITERS);
    localparam logic [CntW-1:0] LastIter = CntW'(MULDIV_ITERS - 1);

    muldiv_state_t      state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend/quotient bits}.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    // Multiplicand or divisor magnitude.
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               neg_lo_q, neg_lo_d;
    logic               neg_hi_q, neg_hi_d;
    logic               is_mul_q, is_mul_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    muldiv_op_t         op_e;
    logic               op_signed;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               sign_diff;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   div_rem;
    logic [WIDTH-1:0]   div_quo;
    logic [2*WIDTH-1:0] prod_fixed;
`ifdef MIPS_MULT_FAST_EN
    logic [2*WIDTH-1:0] fast_prod;
`endif

    mips_cpu_div_step #(
        .WIDTH(WIDTH)
    ) u_div_step (
        .rem_in (acc_q[2*WIDTH-1:WIDTH]),
        .quo_in (acc_q[WIDTH-1:0]),
        .divisor(opnd_q),
        .rem_out(div_rem),
        .quo_out(div_quo)
    );

    // Operand decode and datapath helpers.
    always_comb begin
        op_e       = muldiv_op_t'(op_code);
        op_signed  = (op_e == OpMult) || (op_e == OpDiv);
        a_mag      = mag32(operand_a, op_signed);
        b_mag      = mag32(operand_b, op_signed);
        sign_diff  = op_signed && (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
        // 33-bit add keeps the carry that shifts into the top of the accumulator.
        mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
        prod_fixed = neg_lo_q ? (~acc_q + 1'b1) : acc_q;
`ifdef MIPS_MULT_FAST_EN
        fast_prod  = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
`endif
    end

    // Next-state: FSM, iteration counter and HI/LO commit.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        is_mul_d = is_mul_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (op_valid) begin
                    case (op_e)
                        OpMthi: hi_d = operand_a;
                        OpMtlo: lo_d = operand_a;
                        OpMult, OpMultu: begin
                            is_mul_d = 1'b1;
                            neg_lo_d = sign_diff;
                            neg_hi_d = sign_diff;
                            opnd_d   = b_mag;
`ifdef MIPS_MULT_FAST_EN
                            acc_d    = fast_prod;
                            state_d  = StFinish;
`else
                            acc_d    = {{WIDTH{1'b0}}, a_mag};
                            cnt_d    = LastIter;
                            state_d  = StMul;
`endif
                        end
                        OpDiv, OpDivu: begin
                            is_mul_d = 1'b0;
                            if (operand_b == '0) begin
                                // Divide by zero: fixed result, no sign fix.
                                acc_d    = {operand_a, {WIDTH{1'b1}}};
                                neg_lo_d = 1'b0;
                                neg_hi_d = 1'b0;
                                state_d  = StFinish;
                            end else begin
                                acc_d    = {{WIDTH{1'b0}}, a_mag};
                                opnd_d   = b_mag;
                                neg_lo_d = sign_diff;
                                neg_hi_d = op_signed && operand_a[WIDTH-1];
                                cnt_d    = LastIter;
                                state_d  = StDiv;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            StMul: begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                if (cnt_q == '0) begin
                    state_d = StFinish;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDiv: begin
                acc_d = {div_rem, div_quo};
                if (cnt_q == '0) begin
                    state_d = StFinish;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StFinish: begin
                if (is_mul_q) begin
                    hi_d = prod_fixed[2*WIDTH-1:WIDTH];
                    lo_d = prod_fixed[WIDTH-1:0];
                end else begin
                    hi_d = neg_hi_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1)
                                    : acc_q[2*WIDTH-1:WIDTH];
                    lo_d = neg_lo_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            is_mul_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            is_mul_q <= is_mul_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mips_cpu_mult_div.sv
// Directed bench for mips_cpu_mult_div: table of operations with expected
// HI/LO and busy length, plus hand-written MTHI/MTLO, abort and ignore cases.
module tb_mips_cpu_mult_div;
    import mips_cpu_pkg::*;

`ifdef MIPS_MULT_FAST_EN
    localparam int MulCyc = 1;
`else
    localparam int MulCyc = 33;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        op_valid = 1'b0;
    logic [2:0]  op_code = 3'd0;
    logic [31:0] operand_a = 32'd0;
    logic [31:0] operand_b = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        muldiv_op_t  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          cyc;
    } vec_t;

    vec_t vecs[12];
    logic [31:0] prev_hi;
    logic [31:0] prev_lo;

    mips_cpu_mult_div #(
        .WIDTH(32)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .op_valid (op_valid),
        .op_code  (op_code),
        .operand_a(operand_a),
        .operand_b(operand_b),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One-cycle request; returns at the falling edge after the acceptance edge.
    task automatic issue(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op_valid  = 1'b1;
        op_code   = op;
        operand_a = a;
        operand_b = b;
        @(negedge clk);
        op_valid  = 1'b0;
        op_code   = 3'd0;
    endtask

    task automatic run_op(input string name, input vec_t v,
                          input logic [31:0] hold_hi, input logic [31:0] hold_lo);
        int   cyc = 0;
        int   early_done = 0;
        logic hold_ok = 1'b1;
        issue(v.op, v.a, v.b);
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            if (done !== 1'b0) early_done++;
            if (hi !== hold_hi || lo !== hold_lo) hold_ok = 1'b0;
            @(negedge clk);
        end
        check({name, " busy_cycles"}, 32'(cyc), 32'(v.cyc));
        check({name, " done_pulse"}, {31'd0, done}, 32'd1);
        check({name, " hi"}, hi, v.exp_hi);
        check({name, " lo"}, lo, v.exp_lo);
        check({name, " hold_hilo"}, {31'd0, hold_ok}, 32'd1);
        check({name, " no_early_done"}, 32'(early_done), 32'd0);
        @(negedge clk);
        check({name, " done_cleared"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int cyc;

        vecs[0]  = '{OpMultu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MulCyc};
        vecs[1]  = '{OpMult,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, MulCyc};
        vecs[2]  = '{OpDiv,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33};
        vecs[3]  = '{OpDivu,  32'd100,      32'd7,        32'd2,        32'd14,       33};
        vecs[4]  = '{OpDivu,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1};
        vecs[5]  = '{OpDiv,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 33};
        vecs[6]  = '{OpMult,  32'h80000000, 32'h80000000, 32'h40000000, 32'd0,        MulCyc};
        vecs[7]  = '{OpMult,  32'd7,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, MulCyc};
        vecs[8]  = '{OpDiv,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 33};
        vecs[9]  = '{OpMultu, 32'h12345678, 32'h10,       32'd1,        32'h23456780, MulCyc};
        vecs[10] = '{OpDiv,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1};
        vecs[11] = '{OpDivu,  32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 33};

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        reset = 1'b1;

        // MTHI / MTLO write on the next edge without busy or done.
        issue(OpMthi, 32'h12345678, 32'd0);
        check("mthi hi", hi, 32'h12345678);
        check("mthi busy", {31'd0, busy}, 32'd0);
        check("mthi done", {31'd0, done}, 32'd0);
        issue(OpMtlo, 32'hCAFEF00D, 32'd0);
        check("mtlo lo", lo, 32'hCAFEF00D);
        check("mtlo hi_kept", hi, 32'h12345678);
        check("mtlo busy", {31'd0, busy}, 32'd0);

        // MTHI while a divide is in flight is ignored.
        issue(OpDivu, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        op_valid  = 1'b1;
        op_code   = OpMthi;
        operand_a = 32'hDEADBEEF;
        @(negedge clk);
        op_valid  = 1'b0;
        op_code   = 3'd0;
        check("mthi_busy hi_held", hi, 32'h12345678);
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        check("mthi_busy busy_tail", 32'(cyc), 32'd29);
        check("mthi_busy hi", hi, 32'd2);
        check("mthi_busy lo", lo, 32'd14);
        check("mthi_busy done", {31'd0, done}, 32'd1);
        @(negedge clk);

        // Table-driven operations.
        prev_hi = 32'd2;
        prev_lo = 32'd14;
        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i], prev_hi, prev_lo);
            prev_hi = vecs[i].exp_hi;
            prev_lo = vecs[i].exp_lo;
        end

        // Reset during cycle 10 of a MULT aborts it.
        issue(OpMult, 32'h1234, 32'h5678);
        repeat (8) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("abort hi", hi, 32'd0);
        check("abort lo", lo, 32'd0);
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        @(negedge clk);
        check("abort no_late_done", {31'd0, done}, 32'd0);
        run_op("post_abort", '{OpMultu, 32'd2, 32'd3, 32'd0, 32'd6, MulCyc}, 32'd0, 32'd0);

        // NOP and reserved opcode leave everything alone.
        issue(OpNop, 32'hAAAA5555, 32'd1);
        check("nop busy", {31'd0, busy}, 32'd0);
        check("nop hi", hi, 32'd0);
        check("nop lo", lo, 32'd6);
        issue(OpRsvd, 32'hAAAA5555, 32'd1);
        check("rsvd busy", {31'd0, busy}, 32'd0);
        check("rsvd hi", hi, 32'd0);
        check("rsvd lo", lo, 32'd6);
        check("rsvd done", {31'd0, done}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
